countdown_timer: RTL and testbench



---
 rtl/relogio_pkg.sv | 37 +++
 rtl/countdown_timer_tick_gen.sv | 42 ++++
 rtl/countdown_timer.sv | 133 +++++++++++++
 tb/tb_countdown_timer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/relogio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : relogio_pkg
//  Description : Shared types and constants for the two-digit BCD clock
//                blocks (00..59 up-counter and 59..00 countdown timer).
//  Revision    : 1.0 - initial release
// ============================================================================
package relogio_pkg;

    // Digit widths shared by every block that drives the two-digit display
    localparam int DEZ_W = 3;
    localparam int UNI_W = 4;

    // Largest legal value of each digit
    localparam logic [DEZ_W-1:0] MAX_DEZ = 3'd5;
    localparam logic [UNI_W-1:0] MAX_UNI = 4'd9;

    // Countdown timer control states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } cd_state_t;

    // Saturate a tens digit to MAX_DEZ (out-of-range values clamp, never wrap)
    function automatic logic [DEZ_W-1:0] clamp_dez(input logic [DEZ_W-1:0] d);
        return (d > MAX_DEZ) ? MAX_DEZ : d;
    endfunction

    // Saturate a units digit to MAX_UNI
    function automatic logic [UNI_W-1:0] clamp_uni(input logic [UNI_W-1:0] u);
        return (u > MAX_UNI) ? MAX_UNI : u;
    endfunction

endpackage
`default_nettype wire

// File: rtl/countdown_timer_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : Count-step prescaler. While enabled it counts 0..TICK_DIV-1
//                and flags the terminal count as a tick; clr restarts the
//                phase, and dropping en freezes it so a resume keeps the
//                residual phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int              CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    // Tick only fires on the terminal phase of an enabled cycle
    assign tick = en && (r_cnt == LAST);

    // Phase counter: cleared by reset/clr, advances only while enabled
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            if (r_cnt == LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer
//  Description : Two-digit BCD countdown timer 59..00 with load, start/pause
//                control, clock prescaler and a one-cycle done pulse.
//                Output format (dez/uni) matches the 00..59 up-counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer
    import relogio_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DEZ_W-1:0] load_dez,
    input  logic [UNI_W-1:0] load_uni,
    input  logic             start,
    input  logic             pause,
    output logic [DEZ_W-1:0] dez,
    output logic [UNI_W-1:0] uni,
    output logic             running,
    output logic             done
);

    cd_state_t        r_state;
    cd_state_t        w_state_nxt;
    logic [DEZ_W-1:0] r_dez;
    logic [DEZ_W-1:0] w_dez_nxt;
    logic [UNI_W-1:0] r_uni;
    logic [UNI_W-1:0] w_uni_nxt;
    logic             r_done;
    logic             w_done_nxt;

    logic             w_zero;
    logic             w_start_ok;
    logic             w_en;
    logic             w_clr;
    logic             w_tick;

    assign w_zero = (r_dez == '0) && (r_uni == '0);

    // An asserted pause always outranks start, so start acts only without it
    assign w_start_ok = start && !pause && !w_zero &&
                        ((r_state == IDLE) || (r_state == PAUSED));

    // Prescaler runs only on RUN cycles that are not overridden by load/pause
    assign w_en  = (r_state == RUN) && !load && !pause;

    // Load always restarts the phase; a fresh start from IDLE does too,
    // while resuming from PAUSED keeps the residual phase
    assign w_clr = load || (w_start_ok && (r_state == IDLE));

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .en   (w_en),
        .tick (w_tick)
    );

    // Next-state, BCD borrow and done-pulse decode (load > pause > start)
    always_comb begin
        w_state_nxt = r_state;
        w_dez_nxt   = r_dez;
        w_uni_nxt   = r_uni;
        w_done_nxt  = 1'b0;

        if (load) begin
            w_state_nxt = IDLE;
            w_dez_nxt   = clamp_dez(load_dez);
            w_uni_nxt   = clamp_uni(load_uni);
        end else if (pause) begin
            if (r_state == RUN) begin
                w_state_nxt = PAUSED;
            end
        end else begin
            case (r_state)
                IDLE, PAUSED: begin
                    if (w_start_ok) begin
                        w_state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (w_tick) begin
                        if (r_uni != '0) begin
                            w_uni_nxt = r_uni - UNI_W'(1);
                        end else begin
                            w_uni_nxt = MAX_UNI;
                            w_dez_nxt = r_dez - DEZ_W'(1);
                        end
                        // Only 01 -> 00 can land on zero
                        if ((r_dez == '0) && (r_uni == UNI_W'(1))) begin
                            w_state_nxt = DONE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
                DONE: begin
                    w_state_nxt = DONE;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // State, count and done registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_dez   <= '0;
            r_uni   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dez   <= w_dez_nxt;
            r_uni   <= w_uni_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign dez     = r_dez;
    assign uni     = r_uni;
    assign done    = r_done;
    assign running = (r_state == RUN);

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_countdown_timer
//  Description : Self-checking bench for countdown_timer. Two instances
//                (TICK_DIV = 1 and 4) share the same stimulus; each is
//                compared every cycle against a seconds-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_countdown_timer;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSED = 2;
    localparam int M_DONE   = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [2:0] load_dez = '0;
    logic [3:0] load_uni = '0;
    logic       start = 1'b0;
    logic       pause = 1'b0;

    logic [2:0] dez1, dez4;
    logic [3:0] uni1, uni4;
    logic       running1, running4;
    logic       done1, done4;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;

    // Model: remaining seconds, mode, prescaler phase, done pulse
    int m_div  [2] = '{1, 4};
    int m_secs [2];
    int m_st   [2];
    int m_ph   [2];
    int m_done [2];

    always #5 clk = ~clk;

    countdown_timer #(.TICK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .load(load), .load_dez(load_dez),
        .load_uni(load_uni), .start(start), .pause(pause),
        .dez(dez1), .uni(uni1), .running(running1), .done(done1)
    );

    countdown_timer #(.TICK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .load(load), .load_dez(load_dez),
        .load_uni(load_uni), .start(start), .pause(pause),
        .dez(dez4), .uni(uni4), .running(running4), .done(done4)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s act=%0d exp=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge of the timer's rules, in whole seconds
    task automatic model_step(input int k);
        int d, u;
        m_done[k] = 0;
        if (rst) begin
            m_secs[k] = 0; m_st[k] = M_IDLE; m_ph[k] = 0;
        end else if (load) begin
            d = (int'(load_dez) > 5) ? 5 : int'(load_dez);
            u = (int'(load_uni) > 9) ? 9 : int'(load_uni);
            m_secs[k] = d * 10 + u; m_st[k] = M_IDLE; m_ph[k] = 0;
        end else if (pause) begin
            if (m_st[k] == M_RUN) m_st[k] = M_PAUSED;
        end else if (m_st[k] == M_RUN) begin
            m_ph[k]++;
            if (m_ph[k] == m_div[k]) begin
                m_ph[k] = 0;
                m_secs[k]--;
                if (m_secs[k] == 0) begin
                    m_st[k] = M_DONE; m_done[k] = 1;
                end
            end
        end else if (start && m_secs[k] != 0 &&
                     (m_st[k] == M_IDLE || m_st[k] == M_PAUSED)) begin
            if (m_st[k] == M_IDLE) m_ph[k] = 0;
            m_st[k] = M_RUN;
        end
    endtask

    task automatic cyc(input logic r, input logic l, input logic [2:0] lz,
                       input logic [3:0] lu, input logic s, input logic p);
        rst = r; load = l; load_dez = lz; load_uni = lu; start = s; pause = p;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 3'd0, 4'd0, 0, 0);
    endtask

    // Continuous comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_on) begin
            chk("dez1",  int'(dez1),     m_secs[0] / 10);
            chk("uni1",  int'(uni1),     m_secs[0] % 10);
            chk("run1",  int'(running1), int'(m_st[0] == M_RUN));
            chk("done1", int'(done1),    m_done[0]);
            chk("dez4",  int'(dez4),     m_secs[1] / 10);
            chk("uni4",  int'(uni4),     m_secs[1] % 10);
            chk("run4",  int'(running4), int'(m_st[1] == M_RUN));
            chk("done4", int'(done4),    m_done[1]);
        end
    end

    initial begin
        int k;
        logic r, l, s, p;
        cyc(1, 0, 3'd0, 4'd0, 0, 0);
        cyc(1, 0, 3'd0, 4'd0, 0, 0);
        chk_on = 1'b1;
        chk("rst_dez", int'(dez1), 0);
        chk("rst_uni", int'(uni4), 0);
        chk("rst_run", int'(running1), 0);
        chk("rst_done", int'(done4), 0);

        // TICK_DIV=1: 59 -> 00 in 59 edges, borrow 50->49 seen
        cyc(0, 1, 3'd5, 4'd9, 0, 0);
        cyc(0, 0, 3'd0, 4'd0, 1, 0);
        chk("t1_run", int'(running1), 1);
        for (int i = 1; i <= 59; i++) begin
            idle(1);
            if (i == 1)  chk("t1_first", int'(uni1), 8);
            if (i == 10) chk("t1_b50", int'(dez1) * 10 + int'(uni1), 49);
            if (i == 58) chk("t1_nodone", int'(done1), 0);
            if (i == 59) begin
                chk("t1_done", int'(done1), 1);
                chk("t1_zero", int'(dez1) * 10 + int'(uni1), 0);
                chk("t1_runlow", int'(running1), 0);
            end
        end
        idle(1);
        chk("t1_pulse", int'(done1), 0);

        // TICK_DIV=4: 03, pause with residual phase, resume
        cyc(0, 1, 3'd0, 4'd3, 0, 0);
        cyc(0, 0, 3'd0, 4'd0, 1, 0);
        idle(5);
        cyc(0, 0, 3'd0, 4'd0, 0, 1);
        chk("t4_paused", int'(uni4), 2);
        idle(10);
        chk("t4_hold", int'(dez4) * 10 + int'(uni4), 2);
        chk("t4_runlow", int'(running4), 0);
        cyc(0, 0, 3'd0, 4'd0, 1, 1);
        chk("t4_pausewins", int'(running4), 0);
        cyc(0, 0, 3'd0, 4'd0, 1, 0);
        for (int i = 1; i <= 7; i++) begin
            idle(1);
            if (i == 6) chk("t4_nodone", int'(done4), 0);
            if (i == 7) chk("t4_done", int'(done4), 1);
        end

        // Clamp and zero start
        cyc(0, 1, 3'd7, 4'd12, 0, 0);
        chk("clamp", int'(dez1) * 10 + int'(uni1), 59);
        cyc(0, 1, 3'd0, 4'd0, 0, 0);
        cyc(0, 0, 3'd0, 4'd0, 1, 0);
        chk("zero_start", int'(running1), 0);
        idle(3);
        chk("zero_done", int'(done1), 0);

        // Load together with start
        cyc(0, 1, 3'd2, 4'd0, 1, 0);
        chk("ldst_val", int'(dez1) * 10 + int'(uni1), 20);
        chk("ldst_idle", int'(running1), 0);
        cyc(0, 0, 3'd0, 4'd0, 1, 0);
        idle(1);
        chk("ldst_19", int'(dez1) * 10 + int'(uni1), 19);

        // Reset mid-run
        cyc(0, 1, 3'd3, 4'd5, 0, 0);
        cyc(0, 0, 3'd0, 4'd0, 1, 0);
        idle(4);
        chk("rst_31", int'(dez1) * 10 + int'(uni1), 31);
        cyc(1, 0, 3'd0, 4'd0, 0, 0);
        chk("rst_mid", int'(dez1) * 10 + int'(uni1), 0);
        chk("rst_midrun", int'(running1), 0);
        cyc(0, 0, 3'd0, 4'd0, 1, 0);
        chk("rst_nostart", int'(running1), 0);

        // DONE holds until load
        cyc(0, 1, 3'd1, 4'd0, 0, 0);
        cyc(0, 0, 3'd0, 4'd0, 1, 0);
        idle(10);
        chk("d_done", int'(done1), 1);
        cyc(0, 0, 3'd0, 4'd0, 1, 0);
        chk("d_nostart", int'(running1), 0);
        cyc(0, 1, 3'd0, 4'd5, 0, 0);
        chk("d_load", int'(dez1) * 10 + int'(uni1), 5);

        // Randomized control traffic
        for (int i = 0; i < 4000; i++) begin
            k = int'($urandom_range(0, 99));
            r = (k == 0);
            l = (k >= 1 && k <= 4);
            s = ($urandom_range(0, 99) < 20);
            p = ($urandom_range(0, 99) < 6);
            cyc(r, l, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), s, p);
        end

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
